bus_arbiter: RTL

- Two-master, one-slave arbiter in front of the system bridge. Shares the bridge's processor-side bus between the CPU (master 0) and a second bus master such as a DMA engine (master 1).
- Each granted transfer is presented to the bridge, completion is waited for via s_ready, then acknowledged back to its owner.
- Round-robin arbitration with a bounded burst length prevents starvation.

---
 rtl/bus_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of the system bridge.
// Each granted transfer is presented, completed on s_ready, then acked back to its owner.
module bus_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_we,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_we,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          s_valid,
    output logic [AW-1:0] s_addr,
    output logic          s_we,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_ready,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    state_t     state;
    logic       last;
    logic [3:0] cnt;
    logic       ackp;

    logic   own0, own1, cur_req, oth_req, cur_we;
    state_t oth_state;

    assign own0      = (state == OWN0);
    assign own1      = (state == OWN1);
    assign cur_req   = (own0 & m0_req) | (own1 & m1_req);
    assign oth_req   = (own0 & m1_req) | (own1 & m0_req);
    assign cur_we    = own0 ? m0_we : m1_we;
    assign oth_state = own0 ? OWN1 : OWN0;

    // Grants come straight from the state register, so they are glitch-free and never both high.
    assign m0_gnt  = own0;
    assign m1_gnt  = own1;
    assign busy    = (state != IDLE);
    assign s_valid = cur_req & ~ackp;
    assign s_we    = s_valid & cur_we;
    assign s_addr  = own0 ? m0_addr  : (own1 ? m1_addr  : '0);
    assign s_wdata = own0 ? m0_wdata : (own1 ? m1_wdata : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            cnt      <= '0;
            ackp     <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            ackp   <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req && (!m1_req || last)) begin
                        state <= OWN0;
                        cnt   <= '0;
                    end else if (m1_req) begin
                        state <= OWN1;
                        cnt   <= '0;
                    end
                end
                OWN0, OWN1: begin
                    if (ackp) begin
                        // Burst limit only bites while the other master is actually waiting.
                        if (oth_req && cnt >= BMAX) begin
                            state <= oth_state;
                            cnt   <= '0;
                        end else if (cur_req) begin
                            state <= state;
                        end else if (oth_req) begin
                            state <= oth_state;
                            cnt   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!cur_req) begin
                        if (oth_req) begin
                            state <= oth_state;
                            cnt   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (s_ready) begin
                        ackp <= 1'b1;
                        last <= own1;
                        cnt  <= (cnt == 4'd15) ? cnt : cnt + 4'd1;
                        if (own0) begin
                            m0_ack   <= 1'b1;
                            m0_rdata <= s_rdata;
                        end else begin
                            m1_ack   <= 1'b1;
                            m1_rdata <= s_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
